qam_carrier_sched: RTL

- Schedules one shared 360-entry, single-port sine LUT (1 sample per degree, signed 8-bit, ±100, 1-cycle read latency) between the cosine (I) and sine (Q) carrier fetches of a 16-QAM modulator.
- Accepts Gray-coded 4-bit symbols over a valid/ready handshake, holds each symbol for a fixed number of carrier samples, and emits mixed samples I·cos − Q·sin.
- Sits between the symbol source and the DAC sample path.

---
 rtl/qam_pkg.sv | 28 ++
 rtl/qam_phase_acc.sv | 34 +++
 rtl/qam_carrier_sched.sv | 129 ++++++++++++
 3 files changed

// File: rtl/qam_pkg.sv
// Shared constants, state encoding and symbol level mapping for the 16-QAM
// carrier scheduler.
package qam_pkg;

  localparam int LUT_DEPTH = 360;
  localparam int QUARTER   = 90;
  localparam int AMP_W     = 8;
  localparam int OUT_W     = 11;
  localparam int ADDR_W    = 9;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    COS  = 2'd1,
    SIN  = 2'd2,
    OUT  = 2'd3
  } state_t;

  // Gray-coded 2-bit axis value to amplitude level -3/-1/+1/+3.
  function automatic logic signed [2:0] gray_to_level(input logic [1:0] g);
    case (g)
      2'b00:   return 3'sb101;
      2'b01:   return 3'sb111;
      2'b11:   return 3'sb001;
      default: return 3'sb011;
    endcase
  endfunction

endpackage

// File: rtl/qam_phase_acc.sv
// Carrier phase accumulator in degrees (0..359) plus the quarter-turn shifted
// address used to read cosine out of the sine table.
module qam_phase_acc
  import qam_pkg::*;
#(
  parameter int PHASE_STEP = 12
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              advance,
  output logic [ADDR_W-1:0] phase,
  output logic [ADDR_W-1:0] cos_addr
);

  localparam logic [ADDR_W:0]   STEP_EXT  = (ADDR_W+1)'(PHASE_STEP);
  localparam logic [ADDR_W:0]   DEPTH_EXT = (ADDR_W+1)'(LUT_DEPTH);
  localparam logic [ADDR_W-1:0] COS_WRAP  = ADDR_W'(LUT_DEPTH - QUARTER);

  logic [ADDR_W:0] sum;

  assign sum = {1'b0, phase} + STEP_EXT;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      phase <= '0;
    end else if (advance) begin
      phase <= (sum >= DEPTH_EXT) ? ADDR_W'(sum - DEPTH_EXT) : sum[ADDR_W-1:0];
    end
  end

  assign cos_addr = (phase >= COS_WRAP) ? (phase - COS_WRAP)
                                        : (phase + ADDR_W'(QUARTER));

endmodule

// File: rtl/qam_carrier_sched.sv
// 16-QAM carrier scheduler: time-shares one single-port sine LUT between the
// cosine and sine fetches and emits I*cos - Q*sin once every three cycles.
module qam_carrier_sched
  import qam_pkg::*;
#(
  parameter int PHASE_STEP      = 12,
  parameter int SAMPLES_PER_SYM = 30
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    en,
  input  logic [3:0]              sym_in,
  input  logic                    sym_valid,
  output logic                    sym_ready,
  output logic [ADDR_W-1:0]       rom_addr,
  input  logic signed [AMP_W-1:0] rom_data,
  output logic signed [OUT_W-1:0] sample_out,
  output logic                    sample_valid,
  output logic                    sym_start,
  output logic                    underrun
);

  localparam int CNT_W = (SAMPLES_PER_SYM > 1) ? $clog2(SAMPLES_PER_SYM) : 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(SAMPLES_PER_SYM - 1);

  state_t                  state, next_state;
  logic                    hold_full;
  logic [3:0]              hold_sym;
  logic signed [2:0]       cur_i, cur_q;
  logic [CNT_W-1:0]        cnt;
  logic                    cos_fresh;
  logic signed [AMP_W-1:0] cos_s;
  logic [ADDR_W-1:0]       phase, cos_addr;
  logic                    xfer, out_fire, last_smp, take_hold;

  function automatic logic signed [OUT_W-1:0] mix(
    input logic signed [2:0]       li,
    input logic signed [2:0]       lq,
    input logic signed [AMP_W-1:0] c,
    input logic signed [AMP_W-1:0] s
  );
    logic signed [OUT_W-1:0] a, b;
    a = $signed({{(OUT_W-3){li[2]}}, li}) * $signed({{(OUT_W-AMP_W){c[AMP_W-1]}}, c});
    b = $signed({{(OUT_W-3){lq[2]}}, lq}) * $signed({{(OUT_W-AMP_W){s[AMP_W-1]}}, s});
    return a - b;
  endfunction

  assign sym_ready = !hold_full;
  assign xfer      = sym_valid && !hold_full;
  assign out_fire  = en && (state == OUT);
  assign last_smp  = (cnt == LAST_CNT);

  qam_phase_acc #(
    .PHASE_STEP(PHASE_STEP)
  ) u_phase_acc (
    .clk     (clk),
    .rst     (rst),
    .advance (out_fire),
    .phase   (phase),
    .cos_addr(cos_addr)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (en && hold_full) next_state = COS;
      COS:     if (en) next_state = SIN;
      SIN:     if (en) next_state = OUT;
      OUT:     if (en) next_state = (!last_smp || hold_full) ? COS : IDLE;
      default: next_state = IDLE;
    endcase
  end

  // OUT keeps addressing the sine sample so a stalled OUT re-reads it.
  always_comb begin
    rom_addr  = '0;
    take_hold = 1'b0;
    case (state)
      IDLE:    take_hold = en && hold_full;
      COS:     rom_addr = cos_addr;
      SIN:     rom_addr = phase;
      OUT: begin
        rom_addr  = phase;
        take_hold = en && last_smp && hold_full;
      end
      default: rom_addr = '0;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hold_full    <= 1'b0;
      cnt          <= '0;
      cos_fresh    <= 1'b0;
      sample_out   <= '0;
      sample_valid <= 1'b0;
      sym_start    <= 1'b0;
      underrun     <= 1'b0;
    end else begin
      cos_fresh <= (state == COS);
      if (take_hold)  hold_full <= 1'b0;
      else if (xfer)  hold_full <= 1'b1;
      if (take_hold)                  cnt <= '0;
      else if (out_fire && !last_smp) cnt <= cnt + 1'b1;
      // Output stage: mixed sample registered as it leaves OUT.
      sample_valid <= out_fire;
      sym_start    <= out_fire && (cnt == '0);
      underrun     <= out_fire && last_smp && !hold_full;
      if (out_fire) sample_out <= mix(cur_i, cur_q, cos_s, rom_data);
    end
  end

  // cos_s is taken on the first SIN cycle only, when rom_data still holds
  // the cosine fetch, so an en gap inside SIN cannot overwrite it.
  always_ff @(posedge clk) begin
    if (xfer) hold_sym <= sym_in;
    if (take_hold) begin
      cur_i <= gray_to_level(hold_sym[3:2]);
      cur_q <= gray_to_level(hold_sym[1:0]);
    end
    if ((state == SIN) && cos_fresh) cos_s <= rom_data;
  end

endmodule
